// File: rtl/mem_axi_pkg.sv
// Shared constants, types and helpers for the 64-to-128-bit AXI lane steering bridge.
package mem_axi_pkg;

  localparam logic [3:0]  DDR_NIBBLE_DEF = 4'h1;
  localparam int unsigned UP_DATA_W      = 64;
  localparam int unsigned DN_DATA_W      = 128;
  localparam int unsigned UP_ADDR_W      = 32;
  localparam int unsigned DN_ADDR_W      = 49;
  localparam int unsigned UP_ID_W_DEF    = 4;
  localparam int unsigned DN_ID_W_DEF    = 6;
  localparam int unsigned UP_STRB_W      = UP_DATA_W / 8;
  localparam int unsigned DN_STRB_W      = DN_DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  // Per-burst read context: only the low offset bits matter for lane selection
  typedef struct packed {
    logic [3:0] off;
    logic [2:0] size;
    logic [1:0] burst;
  } rd_entry_t;

  // Beat address advance; the lane bit only ever sees the low nibble
  function automatic logic [11:0] beat_advance(input logic [11:0] addr,
                                               input logic [2:0]  size,
                                               input logic [1:0]  burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (12'd1 << size);
  endfunction

  // Sizes wider than the 64-bit upstream bus, or WRAP on a partial beat
  function automatic logic size_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd3) || ((burst == BURST_WRAP) && (size != 3'd3));
  endfunction

endpackage

// File: rtl/mem_axi_lane_steer_rd_lane_fifo.sv
// Read-burst tracker FIFO: holds lane context for each outstanding read burst.
module rd_lane_fifo
  import mem_axi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  rd_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output rd_entry_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rd_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; power-of-2 depth lets pointers wrap naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_axi_lane_steer.sv
// Bridges the 64-bit AXI4 core memory master onto the 128-bit DDR slave port.
module mem_axi_lane_steer
  import mem_axi_pkg::*;
#(
  parameter int unsigned UP_ID_W    = UP_ID_W_DEF,
  parameter logic [3:0]  DDR_NIBBLE = DDR_NIBBLE_DEF,
  parameter int unsigned RD_DEPTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_aw_valid,
  output logic                   s_aw_ready,
  input  logic [UP_ID_W-1:0]     s_aw_id,
  input  logic [UP_ADDR_W-1:0]   s_aw_addr,
  input  logic [7:0]             s_aw_len,
  input  logic [2:0]             s_aw_size,
  input  logic [1:0]             s_aw_burst,
  input  logic                   s_aw_lock,
  input  logic [3:0]             s_aw_cache,
  input  logic [2:0]             s_aw_prot,
  input  logic [3:0]             s_aw_qos,
  input  logic                   s_w_valid,
  output logic                   s_w_ready,
  input  logic [UP_DATA_W-1:0]   s_w_data,
  input  logic [UP_STRB_W-1:0]   s_w_strb,
  input  logic                   s_w_last,
  output logic                   s_b_valid,
  input  logic                   s_b_ready,
  output logic [UP_ID_W-1:0]     s_b_id,
  output logic [1:0]             s_b_resp,
  input  logic                   s_ar_valid,
  output logic                   s_ar_ready,
  input  logic [UP_ID_W-1:0]     s_ar_id,
  input  logic [UP_ADDR_W-1:0]   s_ar_addr,
  input  logic [7:0]             s_ar_len,
  input  logic [2:0]             s_ar_size,
  input  logic [1:0]             s_ar_burst,
  input  logic                   s_ar_lock,
  input  logic [3:0]             s_ar_cache,
  input  logic [2:0]             s_ar_prot,
  input  logic [3:0]             s_ar_qos,
  output logic                   s_r_valid,
  input  logic                   s_r_ready,
  output logic [UP_ID_W-1:0]     s_r_id,
  output logic [UP_DATA_W-1:0]   s_r_data,
  output logic [1:0]             s_r_resp,
  output logic                   s_r_last,
  output logic                   m_aw_valid,
  input  logic                   m_aw_ready,
  output logic [UP_ID_W+1:0]     m_aw_id,
  output logic [DN_ADDR_W-1:0]   m_aw_addr,
  output logic [7:0]             m_aw_len,
  output logic [2:0]             m_aw_size,
  output logic [1:0]             m_aw_burst,
  output logic                   m_aw_lock,
  output logic [3:0]             m_aw_cache,
  output logic [2:0]             m_aw_prot,
  output logic [3:0]             m_aw_qos,
  output logic                   m_w_valid,
  input  logic                   m_w_ready,
  output logic [DN_DATA_W-1:0]   m_w_data,
  output logic [DN_STRB_W-1:0]   m_w_strb,
  output logic                   m_w_last,
  input  logic                   m_b_valid,
  output logic                   m_b_ready,
  input  logic [UP_ID_W+1:0]     m_b_id,
  input  logic [1:0]             m_b_resp,
  output logic                   m_ar_valid,
  input  logic                   m_ar_ready,
  output logic [UP_ID_W+1:0]     m_ar_id,
  output logic [DN_ADDR_W-1:0]   m_ar_addr,
  output logic [7:0]             m_ar_len,
  output logic [2:0]             m_ar_size,
  output logic [1:0]             m_ar_burst,
  output logic                   m_ar_lock,
  output logic [3:0]             m_ar_cache,
  output logic [2:0]             m_ar_prot,
  output logic [3:0]             m_ar_qos,
  input  logic                   m_r_valid,
  output logic                   m_r_ready,
  input  logic [UP_ID_W+1:0]     m_r_id,
  input  logic [DN_DATA_W-1:0]   m_r_data,
  input  logic [1:0]             m_r_resp,
  input  logic                   m_r_last,
  output logic                   err_size
);

  localparam int unsigned DN_ID_W = UP_ID_W + 2;

  w_state_t             state, state_n;
  logic [11:0]          cur_addr;
  logic [2:0]           w_size;
  logic [1:0]           w_burst;
  logic                 aw_hs, w_hs, ar_hs, r_hs;

  logic                 fifo_full, fifo_empty;
  rd_entry_t            head, ar_entry;
  logic [UP_ID_W-1:0]   rd_id;
  logic                 ar_ok;
  logic                 mid_burst;
  logic [3:0]           r_off;
  logic [3:0]           eff_off;
  logic [11:0]          r_adv;
  logic                 unused_bits;

  // Attribute pass-through, DDR window remap and ID widening
  assign m_aw_id    = {2'b00, s_aw_id};
  assign m_aw_addr  = {17'd0, DDR_NIBBLE, s_aw_addr[27:0]};
  assign m_aw_len   = s_aw_len;
  assign m_aw_size  = s_aw_size;
  assign m_aw_burst = s_aw_burst;
  assign m_aw_lock  = s_aw_lock;
  assign m_aw_cache = s_aw_cache;
  assign m_aw_prot  = s_aw_prot;
  assign m_aw_qos   = s_aw_qos;
  assign m_ar_id    = {2'b00, s_ar_id};
  assign m_ar_addr  = {17'd0, DDR_NIBBLE, s_ar_addr[27:0]};
  assign m_ar_len   = s_ar_len;
  assign m_ar_size  = s_ar_size;
  assign m_ar_burst = s_ar_burst;
  assign m_ar_lock  = s_ar_lock;
  assign m_ar_cache = s_ar_cache;
  assign m_ar_prot  = s_ar_prot;
  assign m_ar_qos   = s_ar_qos;

  // Write beat steering: duplicate data, strobe selects the lane
  assign m_w_data = {s_w_data, s_w_data};
  assign m_w_strb = cur_addr[3] ? {s_w_strb, 8'h00} : {8'h00, s_w_strb};
  assign m_w_last = s_w_last;
  assign s_b_id   = m_b_id[UP_ID_W-1:0];
  assign s_b_resp = m_b_resp;

  assign aw_hs = s_aw_valid && s_aw_ready;
  assign w_hs  = s_w_valid && s_w_ready;

  // Write FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= W_IDLE;
    else       state <= state_n;
  end

  // Write FSM next state and channel gating
  always_comb begin
    state_n    = state;
    m_aw_valid = 1'b0;
    s_aw_ready = 1'b0;
    m_w_valid  = 1'b0;
    s_w_ready  = 1'b0;
    s_b_valid  = 1'b0;
    m_b_ready  = 1'b0;
    case (state)
      W_IDLE: begin
        m_aw_valid = s_aw_valid;
        s_aw_ready = m_aw_ready;
        if (s_aw_valid && m_aw_ready) state_n = W_DATA;
      end
      W_DATA: begin
        m_w_valid = s_w_valid;
        s_w_ready = m_w_ready;
        if (s_w_valid && m_w_ready && s_w_last) state_n = W_RESP;
      end
      W_RESP: begin
        s_b_valid = m_b_valid;
        m_b_ready = s_b_ready;
        if (m_b_valid && s_b_ready) state_n = W_IDLE;
      end
      default: state_n = W_IDLE;
    endcase
  end

  // Write beat address tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_addr <= '0;
      w_size   <= '0;
      w_burst  <= '0;
    end else if (aw_hs) begin
      cur_addr <= s_aw_addr[11:0];
      w_size   <= s_aw_size;
      w_burst  <= s_aw_burst;
    end else if (w_hs) begin
      cur_addr <= beat_advance(cur_addr, w_size, w_burst);
    end
  end

  // Read admission: only one ID outstanding, so responses stay in order
  assign ar_ok      = !fifo_full && (fifo_empty || (s_ar_id == rd_id));
  assign m_ar_valid = s_ar_valid && ar_ok;
  assign s_ar_ready = m_ar_ready && ar_ok;
  assign ar_hs      = s_ar_valid && s_ar_ready;
  assign ar_entry   = '{off: s_ar_addr[3:0], size: s_ar_size, burst: s_ar_burst};

  rd_lane_fifo #(.DEPTH(RD_DEPTH)) u_rd_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (ar_hs),
    .push_data (ar_entry),
    .pop       (r_hs && m_r_last),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Read lane selection; an R beat with nothing outstanding is dropped
  assign s_r_valid = m_r_valid && !fifo_empty;
  assign m_r_ready = s_r_ready && !fifo_empty;
  assign r_hs      = m_r_valid && m_r_ready;
  assign eff_off   = mid_burst ? r_off : head.off;
  assign r_adv     = beat_advance({8'd0, eff_off}, head.size, head.burst);
  assign s_r_data  = eff_off[3] ? m_r_data[127:64] : m_r_data[63:0];
  assign s_r_id    = m_r_id[UP_ID_W-1:0];
  assign s_r_resp  = m_r_resp;
  assign s_r_last  = m_r_last;

  // Read beat offset and outstanding-ID tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mid_burst <= 1'b0;
      r_off     <= '0;
      rd_id     <= '0;
    end else begin
      if (r_hs) begin
        mid_burst <= !m_r_last;
        r_off     <= r_adv[3:0];
      end
      if (ar_hs) rd_id <= s_ar_id;
    end
  end

  // Sticky error on bad sizes or an unsolicited read response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_size <= 1'b0;
    end else if ((aw_hs && size_bad(s_aw_size, s_aw_burst)) ||
                 (ar_hs && size_bad(s_ar_size, s_ar_burst)) ||
                 (m_r_valid && fifo_empty)) begin
      err_size <= 1'b1;
    end
  end

  assign unused_bits = ^{s_aw_addr[31:28], s_ar_addr[31:28],
                         m_b_id[DN_ID_W-1:UP_ID_W], m_r_id[DN_ID_W-1:UP_ID_W],
                         r_adv[11:4]};

endmodule

// File: doc/mem_axi_lane_steer.md
# mem_axi_lane_steer

Downstream of the Rocket `Top` memory port, this block converts the core's 64-bit AXI4 memory master into the 128-bit, 49-bit-address AXI4 slave port of the `soc` DDR path. Each 64-bit beat is steered onto the correct 64-bit half of the 128-bit bus, with a matching 16-bit strobe. On reads, the correct half is selected back out. Addresses are remapped into the DDR window, and IDs are resized. One narrow beat maps to one wide beat; no packing is done, so `len` passes through unchanged.

## Interface
- `UP_ID_W`, 4: upstream ID width. Downstream ID width is `UP_ID_W`+2.
- `DDR_NIBBLE`, 4'h1: value placed on downstream address bits [31:28].
- `RD_DEPTH`, 4: maximum outstanding read bursts. Must be a power of 2.
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `s_aw_*` in/out: `valid`/`ready` plus `id`[4], `addr`[32], `len`[8], `size`[3], `burst`[2], `lock`, `cache`[4], `prot`[3], `qos`[4].
- `s_w_*` in/out: `valid`/`ready` plus `data`[64], `strb`[8], `last`.
- `s_b_*` out/in: `valid`/`ready` plus `id`[4], `resp`[2].
- `s_ar_*` in/out: same fields as `s_aw_*`.
- `s_r_*` out/in: `valid`/`ready` plus `id`[4], `data`[64], `resp`[2], `last`.
- `m_aw_*`, `m_w_*`, `m_b_*`, `m_ar_*`, `m_r_*`: mirror of the `s_*` channels, with these widths: `id`[6], `addr`[49], `data`[128], `strb`[16].
- `err_size` out 1: sticky flag. Set when an AW or AR arrives with `size`>3, or with `burst`=WRAP and `size`≠3.

## Operation
- Address remap: `m_addr` = {17'd0, `DDR_NIBBLE`, `s_addr`[27:0]}.
- IDs: downstream ID = {2'b00, `s_id`}. Response IDs are truncated back to bits [3:0].
- All other AW/AR attribute fields pass through unchanged.
- Write FSM has three states: `W_IDLE`, `W_DATA`, `W_RESP`. Only one write is outstanding at a time.
  - `W_IDLE`: `s_aw_ready` = `m_aw_ready`. On the AW handshake, capture `addr`[11:0], `size` and `burst`, then go to `W_DATA`. `s_w_ready` is 0 in this state.
  - `W_DATA`: `m_w_valid` = `s_w_valid` and `s_w_ready` = `m_w_ready`.
    - Lane is `cur_addr`[3].
    - `m_w_data` = {`s_w_data`, `s_w_data`}.
    - `m_w_strb` = lane ? {`strb`, 8'h00} : {8'h00, `strb`}.
    - After each beat, `cur_addr` += (1 << `size`) for INCR and WRAP; it is unchanged for FIXED.
    - On the beat with `last`, go to `W_RESP`.
  - `W_RESP`: B passes straight through. On the `s_b` handshake, go to `W_IDLE`. AW is blocked.
- Read tracker: a FIFO of depth `RD_DEPTH`. Each entry holds {`addr`[3:0], `size`, `burst`}. A register holds the ID of the outstanding reads.
  - `s_ar_ready` = `m_ar_ready` && !full && (empty || `s_ar_id` == `rd_id`).
  - Reads with different IDs are never outstanding together, so responses stay in order.
- R path:
  - `s_r_data` = `head_off`[3] ? `m_r_data`[127:64] : `m_r_data`[63:0].
  - `head_off` is loaded from the head entry and advances per R handshake using the same rule as writes.
  - The head entry pops on an R handshake with `last`.
- `err_size` is set on the offending handshake. The transaction is still forwarded. The flag clears only on reset.

## Timing
- AW, AR, W, B and R are combinational pass-throughs (0-cycle latency) whenever enabled. There are no registered slices.
- Reset values: all `*_valid` outputs 0, FSM in `W_IDLE`, FIFO empty, `rd_id` 0, `err_size` 0.
- `s_w_ready` and `s_aw_ready` must never both be 1 in the same cycle.
- A pop with `last` and an AR push may happen in the same cycle. Full, empty and ID checks use the count before the pop, so a new AR is never admitted through a same-cycle pop.
- A downstream `m_r_valid` arriving with the FIFO empty is a protocol error: tie `s_r_valid` low and set `err_size`.
- Reset during a burst abandons all state. Upstream and downstream are reset together by `sys_reset`.
- `valid` must not depend on `ready` on any `m_*` output.

## Structure
- Package `mem_axi_pkg`: `DDR_NIBBLE` default, width constants (64/128/32/49, ID 4/6), `BURST_FIXED`/`BURST_INCR`/`BURST_WRAP` constants, write FSM state enum, and read tracker entry struct.
- Sub-module `rd_lane_fifo`: parameterised FIFO with push/pop, `full`/`empty` and head output.

## Test plan
- Single-beat write to `addr` 0x8000_0008, `strb` 0xFF, data D → `m_aw_addr` = 0x1000_0008; `m_w_strb` = 0xFF00; `m_w_data` = {D, D}; `s_b_id` echoed.
- INCR write, `len` 3, `size` 3, `addr` 0x0 → `m_w_strb` sequence is 0x00FF, 0xFF00, 0x00FF, 0xFF00; FSM returns to `W_IDLE` after B.
- INCR read, `len` 1, `addr` 0x8, R data {H0, L0} then {H1, L1} → `s_r_data` = H0, then L1; FIFO empty afterwards.
- Four ARs with ID 2 and no R → fifth AR stalled (`s_ar_ready` = 0); ID 3 AR while ID 2 reads are outstanding is also stalled until the last `rlast`.
- AW with `size` 4 → forwarded, `err_size` goes to 1; reset mid-`W_DATA` → all valids 0, `err_size` 0.
